// File: rtl/axa_shared_unit_sequencer.sv
// Sequences a 2x2 FP32 matrix product C=A*B through one shared multiplier and one shared adder.
// Optional unit-handshake timeout is compiled in with `define AXA_SEQ_TIMEOUT_EN.
module axa_shared_unit_sequencer #(
   parameter int DATA_W         = 32,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic              input_Clk,
   input  logic              input_Reset,
   input  logic              input_Start,
   input  logic              input_Stable,
   input  logic [DATA_W-1:0] input_A11,
   input  logic [DATA_W-1:0] input_A12,
   input  logic [DATA_W-1:0] input_A21,
   input  logic [DATA_W-1:0] input_A22,
   input  logic [DATA_W-1:0] input_B11,
   input  logic [DATA_W-1:0] input_B12,
   input  logic [DATA_W-1:0] input_B21,
   input  logic [DATA_W-1:0] input_B22,
   output logic              output_AB_Ack,
   output logic [DATA_W-1:0] output_C11,
   output logic [DATA_W-1:0] output_C12,
   output logic [DATA_W-1:0] output_C21,
   output logic [DATA_W-1:0] output_C22,
   output logic              output_Stable,
   input  logic              input_C_Ack,
   output logic [DATA_W-1:0] output_Mul_A,
   output logic [DATA_W-1:0] output_Mul_B,
   output logic              output_Mul_Stb,
   input  logic              input_Mul_In_Ack,
   input  logic [DATA_W-1:0] input_Mul_Z,
   input  logic              input_Mul_Z_Stb,
   output logic              output_Mul_Z_Ack,
   output logic [DATA_W-1:0] output_Add_N1,
   output logic [DATA_W-1:0] output_Add_N2,
   output logic              output_Add_Load,
   input  logic [DATA_W-1:0] input_Add_Result,
   input  logic              input_Add_Ready,
   output logic              output_Add_Ack,
   output logic              output_Error
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_CAPTURE,
      S_MUL_ISSUE,
      S_MUL_WAIT,
      S_ADD_ISSUE,
      S_ADD_WAIT,
      S_DONE
   } state_t;

   state_t state_q, state_d;

   logic [2:0]        k_q;
   logic [1:0]        j_q;
   logic [DATA_W-1:0] a_q [4];
   logic [DATA_W-1:0] b_q [4];
   logic [DATA_W-1:0] p_q [8];
   logic [DATA_W-1:0] c_q [4];
   logic              ab_ack_q;

   logic capture;
   logic mul_take;
   logic add_take;

`ifdef AXA_SEQ_TIMEOUT_EN
   localparam int TMR_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
   localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);
   localparam logic [TMR_W-1:0] TMR_MAX  = '1;

   logic [TMR_W-1:0] tmr_q;
   logic             error_q;
   logic             timeout;
`endif

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge input_Clk or posedge input_Reset) begin
      if (input_Reset) state_q <= S_IDLE;
      else             state_q <= state_d;
   end

   // NOTE: every signal written here gets a default first, so no path leaves one unassigned (no latch).
   always_comb begin
      state_d          = state_q;
      capture          = 1'b0;
      mul_take         = 1'b0;
      add_take         = 1'b0;
      output_Mul_Stb   = 1'b0;
      output_Mul_Z_Ack = 1'b0;
      output_Add_Load  = 1'b0;
      output_Add_Ack   = 1'b0;
`ifdef AXA_SEQ_TIMEOUT_EN
      timeout          = 1'b0;
`endif

      case (state_q)
         S_IDLE: begin
            if (input_Start) state_d = S_CAPTURE;
         end
         S_CAPTURE: begin
            if (input_Stable) begin
               capture = 1'b1;
               state_d = S_MUL_ISSUE;
            end
         end
         S_MUL_ISSUE: begin
            output_Mul_Stb = 1'b1;
            if (input_Mul_In_Ack) state_d = S_MUL_WAIT;
         end
         S_MUL_WAIT: begin
            if (input_Mul_Z_Stb) begin
               output_Mul_Z_Ack = 1'b1;
               mul_take         = 1'b1;
               state_d          = (k_q == 3'd7) ? S_ADD_ISSUE : S_MUL_ISSUE;
            end
         end
         S_ADD_ISSUE: begin
            output_Add_Load = 1'b1;
            state_d         = S_ADD_WAIT;
         end
         S_ADD_WAIT: begin
            if (input_Add_Ready) begin
               output_Add_Ack = 1'b1;
               add_take       = 1'b1;
               state_d        = (j_q == 2'd3) ? S_DONE : S_ADD_ISSUE;
            end
         end
         S_DONE: begin
            if (input_C_Ack) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

`ifdef AXA_SEQ_TIMEOUT_EN
      // A handshake completing on the last allowed cycle wins over the timeout.
      if ((state_q inside {S_MUL_ISSUE, S_MUL_WAIT, S_ADD_WAIT}) &&
          (state_d == state_q) && (tmr_q == TMR_LAST)) begin
         timeout = 1'b1;
         state_d = S_IDLE;
      end
`endif
   end

   // NOTE: operand, product and result registers are reset too, so an aborted run exposes only zeros.
   always_ff @(posedge input_Clk or posedge input_Reset) begin
      if (input_Reset) begin
         k_q      <= '0;
         j_q      <= '0;
         ab_ack_q <= 1'b0;
         for (int i = 0; i < 4; i++) begin
            a_q[i] <= '0;
            b_q[i] <= '0;
            c_q[i] <= '0;
         end
         for (int i = 0; i < 8; i++) p_q[i] <= '0;
      end else begin
         ab_ack_q <= capture;
         if (capture) begin
            a_q[0] <= input_A11;
            a_q[1] <= input_A12;
            a_q[2] <= input_A21;
            a_q[3] <= input_A22;
            b_q[0] <= input_B11;
            b_q[1] <= input_B12;
            b_q[2] <= input_B21;
            b_q[3] <= input_B22;
            k_q    <= '0;
            j_q    <= '0;
         end
         if (mul_take) begin
            p_q[k_q] <= input_Mul_Z;
            k_q      <= k_q + 3'd1;
         end
         if (add_take) begin
            c_q[j_q] <= input_Add_Result;
            j_q      <= j_q + 2'd1;
         end
      end
   end

`ifdef AXA_SEQ_TIMEOUT_EN
   always_ff @(posedge input_Clk or posedge input_Reset) begin
      if (input_Reset) begin
         tmr_q   <= '0;
         error_q <= 1'b0;
      end else begin
         if (state_d != state_q)   tmr_q <= '0;
         else if (tmr_q != TMR_MAX) tmr_q <= tmr_q + 1'b1;

         if (timeout)                               error_q <= 1'b1;
         else if (state_q == S_IDLE && input_Start) error_q <= 1'b0;
      end
   end

   assign output_Error = error_q;
`else
   assign output_Error = 1'b0;
`endif

   // Product k: A row = k[2], A col = k[0]; B row = k[0], B col = k[1].
   assign output_Mul_A  = a_q[{k_q[2], k_q[0]}];
   assign output_Mul_B  = b_q[{k_q[0], k_q[1]}];
   assign output_Add_N1 = p_q[{j_q, 1'b0}];
   assign output_Add_N2 = p_q[{j_q, 1'b1}];

   assign output_AB_Ack = ab_ack_q;
   assign output_Stable = (state_q == S_DONE);
   assign output_C11    = c_q[0];
   assign output_C12    = c_q[1];
   assign output_C21    = c_q[2];
   assign output_C22    = c_q[3];

endmodule

// File: tb/tb_axa_shared_unit_sequencer.sv
// Bench for axa_shared_unit_sequencer: behavioural FP units with programmable latency and stalls,
// vector table plus operand/result scoreboard queues.
module tb_axa_shared_unit_sequencer;

   localparam int DW = 32;

   logic          input_Clk = 1'b0;
   logic          input_Reset;
   logic          input_Start;
   logic          input_Stable;
   logic [DW-1:0] input_A11, input_A12, input_A21, input_A22;
   logic [DW-1:0] input_B11, input_B12, input_B21, input_B22;
   logic          output_AB_Ack;
   logic [DW-1:0] output_C11, output_C12, output_C21, output_C22;
   logic          output_Stable;
   logic          input_C_Ack;
   logic [DW-1:0] output_Mul_A, output_Mul_B;
   logic          output_Mul_Stb;
   logic          input_Mul_In_Ack;
   logic [DW-1:0] input_Mul_Z;
   logic          input_Mul_Z_Stb;
   logic          output_Mul_Z_Ack;
   logic [DW-1:0] output_Add_N1, output_Add_N2;
   logic          output_Add_Load;
   logic [DW-1:0] input_Add_Result;
   logic          input_Add_Ready;
   logic          output_Add_Ack;
   logic          output_Error;

   always #5 input_Clk = ~input_Clk;

   axa_shared_unit_sequencer #(.DATA_W(DW), .TIMEOUT_CYCLES(16)) dut (
      .input_Clk(input_Clk), .input_Reset(input_Reset),
      .input_Start(input_Start), .input_Stable(input_Stable),
      .input_A11(input_A11), .input_A12(input_A12), .input_A21(input_A21), .input_A22(input_A22),
      .input_B11(input_B11), .input_B12(input_B12), .input_B21(input_B21), .input_B22(input_B22),
      .output_AB_Ack(output_AB_Ack),
      .output_C11(output_C11), .output_C12(output_C12), .output_C21(output_C21), .output_C22(output_C22),
      .output_Stable(output_Stable), .input_C_Ack(input_C_Ack),
      .output_Mul_A(output_Mul_A), .output_Mul_B(output_Mul_B), .output_Mul_Stb(output_Mul_Stb),
      .input_Mul_In_Ack(input_Mul_In_Ack), .input_Mul_Z(input_Mul_Z), .input_Mul_Z_Stb(input_Mul_Z_Stb),
      .output_Mul_Z_Ack(output_Mul_Z_Ack),
      .output_Add_N1(output_Add_N1), .output_Add_N2(output_Add_N2), .output_Add_Load(output_Add_Load),
      .input_Add_Result(input_Add_Result), .input_Add_Ready(input_Add_Ready),
      .output_Add_Ack(output_Add_Ack), .output_Error(output_Error)
   );

   int n_checks = 0;
   int n_fails  = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fails++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Exact for non-negative integers below 2^24, which is all these tests use.
   function automatic int fp2int(logic [31:0] f);
      int          e;
      logic [31:0] m;
      if (f[30:0] == 31'd0) return 0;
      e = int'(f[30:23]) - 127;
      m = {8'd0, 1'b1, f[22:0]};
      return int'(m >> (23 - e));
   endfunction

   function automatic logic [31:0] int2fp(int v);
      int          p;
      logic [31:0] u, m;
      if (v == 0) return 32'd0;
      u = v;
      p = 0;
      for (int i = 0; i < 24; i++) if (u[i]) p = i;
      m = u << (23 - p);
      return {1'b0, 8'(p + 127), m[22:0]};
   endfunction

   // ---------------- behavioural multiplier and adder ----------------
   int          mul_lat = 1, add_lat = 1;
   bit          stall_en = 1'b0, mul_never = 1'b0;
   logic        mul_busy, mul_stall, add_busy;
   int          mul_cnt, add_cnt;
   logic [31:0] mul_z, add_z;

   assign input_Mul_In_Ack = output_Mul_Stb && !mul_busy && !mul_stall;
   assign input_Mul_Z_Stb  = mul_busy && (mul_cnt == 0) && !mul_never;
   assign input_Mul_Z      = mul_z;
   assign input_Add_Ready  = add_busy && (add_cnt == 0);
   assign input_Add_Result = add_z;

   always @(posedge input_Clk or posedge input_Reset) begin
      if (input_Reset) begin
         mul_busy <= 1'b0; mul_cnt <= 0; mul_z <= '0; mul_stall <= 1'b0;
         add_busy <= 1'b0; add_cnt <= 0; add_z <= '0;
      end else begin
         mul_stall <= stall_en && ($urandom_range(0, 2) == 0);
         if (!mul_busy && output_Mul_Stb && input_Mul_In_Ack) begin
            mul_busy <= 1'b1;
            mul_cnt  <= mul_lat - 1;
            mul_z    <= int2fp(fp2int(output_Mul_A) * fp2int(output_Mul_B));
         end else if (mul_busy) begin
            if (mul_cnt != 0)          mul_cnt  <= mul_cnt - 1;
            else if (output_Mul_Z_Ack) mul_busy <= 1'b0;
         end
         if (!add_busy && output_Add_Load) begin
            add_busy <= 1'b1;
            add_cnt  <= add_lat - 1;
            add_z    <= int2fp(fp2int(output_Add_N1) + fp2int(output_Add_N2));
         end else if (add_busy) begin
            if (add_cnt != 0)        add_cnt  <= add_cnt - 1;
            else if (output_Add_Ack) add_busy <= 1'b0;
         end
      end
   end

   // ---------------- scoreboard ----------------
   logic [63:0]       exp_ops [$];
   logic [3:0][31:0]  exp_c   [$];
   int                n_mul_acc, n_add_load;

   always @(negedge input_Clk) begin
      if (!input_Reset) begin
         if (output_Mul_Stb && input_Mul_In_Ack) begin
            n_mul_acc++;
            if (exp_ops.size() == 0) begin
               n_checks++;
               n_fails++;
               $display("FAIL mul_unexpected: got operands %h %h, expected no issue", output_Mul_A, output_Mul_B);
            end else begin
               check("mul_operands", {output_Mul_A, output_Mul_B}, exp_ops.pop_front());
            end
         end
         if (output_Add_Load) n_add_load++;
      end
   end

   typedef struct packed {
      logic [3:0][31:0] a;      // index 0..3 = x11, x12, x21, x22
      logic [3:0][31:0] b;
      logic [3:0][31:0] c;
      logic [3:0]       mul_lat;
      logic [3:0]       add_lat;
      logic             stall;
      logic             zero_in;
   } vec_t;

   function automatic logic [3:0][31:0] pack4(logic [31:0] x0, logic [31:0] x1,
                                              logic [31:0] x2, logic [31:0] x3);
      logic [3:0][31:0] r;
      r[0] = x0; r[1] = x1; r[2] = x2; r[3] = x3;
      return r;
   endfunction

   task automatic push_ops(input vec_t v);
      int ai [8] = '{0, 1, 0, 1, 2, 3, 2, 3};
      int bi [8] = '{0, 2, 1, 3, 0, 2, 1, 3};
      for (int k = 0; k < 8; k++) exp_ops.push_back({v.a[ai[k]], v.b[bi[k]]});
   endtask

   task automatic drive_ab(input vec_t v);
      input_A11 = v.a[0]; input_A12 = v.a[1]; input_A21 = v.a[2]; input_A22 = v.a[3];
      input_B11 = v.b[0]; input_B12 = v.b[1]; input_B21 = v.b[2]; input_B22 = v.b[3];
   endtask

   task automatic zero_ab();
      input_A11 = '0; input_A12 = '0; input_A21 = '0; input_A22 = '0;
      input_B11 = '0; input_B12 = '0; input_B21 = '0; input_B22 = '0;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_ctrl"}, {output_AB_Ack, output_Stable, output_Error, output_Mul_Stb,
                             output_Mul_Z_Ack, output_Add_Load, output_Add_Ack}, 64'd0);
      check({tag, "_data"}, output_C11 | output_C12 | output_C21 | output_C22 | output_Mul_A |
                            output_Mul_B | output_Add_N1 | output_Add_N2, 64'd0);
   endtask

   task automatic run_vec(input vec_t v, input bit check_lat, input bit hold_done);
      int               cyc = 0, n_ab = 0;
      bit               done = 1'b0, held = 1'b1;
      logic [3:0][31:0] ce;
      mul_lat = int'(v.mul_lat); add_lat = int'(v.add_lat); stall_en = v.stall;
      n_mul_acc = 0; n_add_load = 0;
      push_ops(v);
      exp_c.push_back(v.c);
      drive_ab(v);
      input_Stable = 1'b1;
      input_Start  = 1'b1;
      while (!done && cyc < 2000) begin
         @(posedge input_Clk); #1;
         cyc++;
         if (cyc == 1) input_Start = 1'b0;
         if (v.stall && cyc == 12) input_Start = 1'b1;   // must be ignored mid-run
         if (v.stall && cyc == 13) input_Start = 1'b0;
         if (output_AB_Ack) begin
            n_ab++;
            input_Stable = 1'b0;
            if (v.zero_in) zero_ab();
         end
         if (output_Stable) done = 1'b1;
      end
      check("stable_seen", done, 1'b1);
      if (check_lat) check("latency", cyc, 26);
      check("ab_ack_pulses", n_ab, 1);
      check("mul_issues", n_mul_acc, 8);
      check("add_loads", n_add_load, 4);
      check("error_low", output_Error, 1'b0);
      ce = exp_c.pop_front();
      check("c11", output_C11, ce[0]);
      check("c12", output_C12, ce[1]);
      check("c21", output_C21, ce[2]);
      check("c22", output_C22, ce[3]);
      if (hold_done) begin
         repeat (20) begin
            @(posedge input_Clk); #1;
            if (!output_Stable || {output_C11, output_C12, output_C21, output_C22} !== {ce[0], ce[1], ce[2], ce[3]})
               held = 1'b0;
         end
         check("done_hold", held, 1'b1);
      end
      input_C_Ack = 1'b1;
      @(posedge input_Clk); #1;
      input_C_Ack = 1'b0;
      check("stable_drop", output_Stable, 1'b0);
      check("ops_drained", exp_ops.size(), 0);
   endtask

   vec_t vecs [4];

   initial begin
      #300000;
      $display("FAIL watchdog: got no end of test, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int   cyc;
      int   t;
      vec_t rv;

      vecs[0].a = pack4(32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000);
      vecs[0].b = pack4(32'h40A00000, 32'h40C00000, 32'h40E00000, 32'h41000000);
      vecs[0].c = pack4(32'h41980000, 32'h41B00000, 32'h422C0000, 32'h42480000);
      vecs[0].mul_lat = 4'd1; vecs[0].add_lat = 4'd1; vecs[0].stall = 1'b0; vecs[0].zero_in = 1'b0;
      vecs[1] = vecs[0];
      vecs[1].mul_lat = 4'd7; vecs[1].add_lat = 4'd3; vecs[1].stall = 1'b1;
      vecs[2] = vecs[0];
      vecs[2].zero_in = 1'b1;
      // A=[2,0;1,3], B=[4,1;5,2] -> C=[8,2;19,7]
      vecs[3].a = pack4(32'h40000000, 32'h00000000, 32'h3F800000, 32'h40400000);
      vecs[3].b = pack4(32'h40800000, 32'h3F800000, 32'h40A00000, 32'h40000000);
      vecs[3].c = pack4(32'h41000000, 32'h40000000, 32'h41980000, 32'h40E00000);
      vecs[3].mul_lat = 4'd2; vecs[3].add_lat = 4'd2; vecs[3].stall = 1'b1; vecs[3].zero_in = 1'b0;

      input_Reset = 1'b1; input_Start = 1'b0; input_Stable = 1'b0; input_C_Ack = 1'b0;
      zero_ab();
      repeat (3) @(posedge input_Clk);
      #1;
      check_reset_outputs("reset");
      input_Reset = 1'b0;
      @(posedge input_Clk); #1;

      for (int i = 0; i < 4; i++) run_vec(vecs[i], i == 0, i == 2);

      // Reset while waiting on the fifth product (k=4).
      rv = vecs[0];
      mul_lat = 5; add_lat = 1; stall_en = 1'b0; n_mul_acc = 0;
      push_ops(rv);
      drive_ab(rv);
      input_Stable = 1'b1; input_Start = 1'b1;
      cyc = 0;
      while (n_mul_acc < 5 && cyc < 500) begin
         @(posedge input_Clk); #1;
         cyc++;
         if (cyc == 1) input_Start = 1'b0;
         if (output_AB_Ack) input_Stable = 1'b0;
      end
      check("reach_k4", n_mul_acc, 5);
      input_Reset = 1'b1;
      #1;
      check_reset_outputs("midrun_reset");
      exp_ops.delete();
      @(posedge input_Clk); @(posedge input_Clk); #1;
      input_Reset = 1'b0;
      @(posedge input_Clk); #1;
      run_vec(vecs[0], 1'b1, 1'b0);

`ifdef AXA_SEQ_TIMEOUT_EN
      // Multiplier accepts but never answers: timeout after 16 cycles in MUL_WAIT.
      mul_never = 1'b1; mul_lat = 1; stall_en = 1'b0; n_mul_acc = 0;
      push_ops(vecs[0]);
      drive_ab(vecs[0]);
      input_Stable = 1'b1; input_Start = 1'b1;
      cyc = 0; t = -1;
      while (!output_Error && cyc < 200) begin
         @(posedge input_Clk); #1;
         cyc++;
         if (cyc == 1) input_Start = 1'b0;
         if (output_AB_Ack) input_Stable = 1'b0;
         if (t >= 0) t++;
         else if (n_mul_acc == 1) t = 0;
      end
      check("timeout_error", output_Error, 1'b1);
      check("timeout_cycles", t, 16);
      check("timeout_idle", {output_Mul_Stb, output_Stable}, 2'b00);
      repeat (3) @(posedge input_Clk);
      #1;
      check("error_sticky", {output_Error, output_Mul_Stb, output_Stable}, 3'b100);
      input_Start = 1'b1; input_Stable = 1'b1;
      @(posedge input_Clk); #1;
      input_Start = 1'b0;
      check("error_cleared", output_Error, 1'b0);
      input_Reset = 1'b1;
      @(posedge input_Clk); #1;
      input_Reset = 1'b0; input_Stable = 1'b0; mul_never = 1'b0;
      exp_ops.delete();
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
